systolic_mm_ctrl: RTL and testbench
===================================

Name: systolic_mm_ctrl

Overview:
- Sequencer for a DIMENSION x DIMENSION output-stationary systolic multiply array built from signed multiply-accumulate PEs.
- Holds operand matrices A and B in local buffers and clears the array.
- Streams skewed A rows into the west edge and skewed B columns into the north edge.
- Snapshots the accumulated C matrix and serializes it out over a valid/ready port.

Parameters:
- DIMENSION, 4, matrix order; array is DIMENSION x DIMENSION PEs.
- I_BITS, 8, operand width, signed two's complement.
- O_BITS, 2*I_BITS+$clog2(DIMENSION), result width per PE (full-resolution accumulator).

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset.
- i_start  in  1  start request; sampled in IDLE only.
- i_wr_en  in  1  operand buffer write strobe.
- i_wr_sel  in  1  0=A buffer, 1=B buffer.
- i_wr_addr  in  $clog2(DIMENSION*DIMENSION)  A: r*D+k; B: k*D+c.
- i_wr_data  in  I_BITS  operand value.
- o_busy  out  1  high in every state except IDLE.
- o_array_reset  out  1  drives all PE resets.
- o_a_edge  out  DIMENSION*I_BITS  lane r at [r*I_BITS +: I_BITS] feeds PE(r,0) a-input.
- o_b_edge  out  DIMENSION*I_BITS  lane c feeds PE(0,c) b-input.
- i_c_flat  in  DIMENSION*DIMENSION*O_BITS  PE(r,c) result at [(r*D+c)*O_BITS +: O_BITS].
- o_c_data  out  O_BITS  serialized result.
- o_c_valid  out  1  result valid.
- i_c_ready  in  1  consumer ready.
- o_c_last  out  1  marks element D*D-1.
- o_done  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset is i_reset, synchronous, active-high; clock is i_clock.
- During reset all outputs are 0, except o_array_reset=1.
- On reset: state=IDLE, counters=0, A/B buffers and snapshot cleared to 0. Reset mid-job aborts immediately; no o_done.
- Writes are accepted only in IDLE and ignored otherwise.
- A write and an i_start in the same cycle: the write commits and the job uses the new value.
- State machine:
  - IDLE: on i_start, go to CLEAR.
  - CLEAR: 1 cycle; o_array_reset=1; edges=0.
  - FEED: t=0..3D-3, 3D-2 cycles. Lane r of o_a_edge = A[r][t-r] when 0<=t-r<D, else 0. Lane c of o_b_edge = B[t-c][c] when 0<=t-c<D, else 0. Edge values are registered outputs.
  - CAPTURE: 1 cycle; edges=0; snapshot <= i_c_flat at cycle end.
  - OUTPUT: index i=0..D*D-1, row-major. o_c_data=snapshot[i]; o_c_valid=1; o_c_last=(i==D*D-1). Advance only on valid&&ready. Data is held stable while stalled.
  - After the last handshake: state=IDLE, o_done=1 for one cycle.
- Timing with i_start sampled at cycle 0:
  - CLEAR at cycle 1.
  - FEED at cycles 2..3D-1.
  - CAPTURE at cycle 3D.
  - First o_c_valid at cycle 3D+1. For D=4: cycle 13.
- With i_c_ready held high, o_done occurs at cycle 3D+D*D+1 (29 for D=4).
- i_start outside IDLE is ignored, with no queuing.
- Array PEs must accumulate throughout all FEED cycles after CLEAR. The controller does not use PE finish flags.
- The controller only routes values, with no arithmetic. Signedness is preserved bit-exactly.
- Edges are 0 in IDLE/CLEAR/CAPTURE/OUTPUT, so the array sees no spurious products.

Decomposition:
- Package systolic_pkg:
  - state encoding: IDLE, CLEAR, FEED, CAPTURE, OUTPUT.
  - FEED_CYCLES=3*DIMENSION-2.
  - address/index width constants.
  - lane slice helper functions.
- Sub-module systolic_result_serializer:
  - snapshot register, index counter, valid/ready/last logic.
  - capture and start are commanded by the FSM; returns a done strobe.

Test Plan:
- D=4, A=identity (1 on diagonal), B[k][c]=4k+c+1, start, ready=1 -> o_c_data sequence 1..16. First valid at cycle 13, o_c_last on 16th, o_done at cycle 29.
- A all 8'hFF (-1), B all 8'h02 -> all 16 results 18'h3FFF8 (-8).
- Throttle: i_c_ready toggles 1,0,0,1 pattern -> no element lost or duplicated. o_c_data stable while valid&&!ready; o_done follows the final handshake by one cycle.
- Skew check: monitor o_a_edge/o_b_edge during FEED -> lane r nonzero only at t in [r, r+3]. At t=0 only lane 0 active; at t=9 all lanes 0.
- i_start pulsed during FEED and OUTPUT -> ignored; i_wr_en during busy -> buffer unchanged; the next job yields the original results.
- Assert i_reset at cycle 7 of a job -> next cycle: state IDLE, o_busy=0, o_c_valid=0, o_array_reset=1 only while reset is held. No o_done; buffers read back 0 on a new job without writes.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic multiply sequencer: state encoding,
// sizing helpers and the lane-skew addressing used to feed the array edges.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    CAPTURE,
    OUTPUT
  } state_e;

  function automatic int feed_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lane l carries element (t - l) of its row/column during feed step t.
  function automatic logic lane_active(input int t, input int lane, input int dim);
    return (t >= lane) && ((t - lane) < dim);
  endfunction

  // A is stored row-major as r*D+k; lane r at step t reads A[r][t-r].
  function automatic int a_addr(input int t, input int r, input int dim);
    return r * dim + (t - r);
  endfunction

  // B is stored as k*D+c; lane c at step t reads B[t-c][c].
  function automatic int b_addr(input int t, input int c, input int dim);
    return (t - c) * dim + c;
  endfunction

endpackage

// File: rtl/systolic_result_serializer.sv
// Snapshots the array result matrix and streams it out row-major over a
// valid/ready port, flagging the final element and pulsing done after it.
module systolic_result_serializer
  import systolic_pkg::*;
#(
  parameter int DIMENSION = 4,
  parameter int O_BITS    = 18
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                capture_i,
  input  logic                                start_i,
  input  logic [DIMENSION*DIMENSION*O_BITS-1:0] c_flat_i,
  input  logic                                ready_i,
  output logic [O_BITS-1:0]                   data_o,
  output logic                                valid_o,
  output logic                                last_o,
  output logic                                fin_o,
  output logic                                done_o
);

  localparam int NE = DIMENSION * DIMENSION;
  localparam int IW = count_width(NE);
  localparam logic [IW-1:0] IDX_LAST = IW'(NE - 1);

  logic [O_BITS-1:0] snap_q [NE];
  logic [IW-1:0]     idx_q;
  logic              valid_q;
  logic              done_q;
  logic              at_last;

  assign at_last = (idx_q == IDX_LAST);
  assign fin_o   = valid_q & ready_i & at_last;
  assign data_o  = valid_q ? snap_q[idx_q] : '0;
  assign valid_o = valid_q;
  assign last_o  = valid_q & at_last;
  assign done_o  = done_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NE; i++) snap_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (capture_i) begin
        for (int i = 0; i < NE; i++) snap_q[i] <= c_flat_i[i*O_BITS +: O_BITS];
      end
      if (start_i) begin
        idx_q   <= '0;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        // Index only moves on a handshake, so data holds steady under back-pressure.
        if (at_last) begin
          idx_q   <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/systolic_mm_ctrl.sv
// Sequencer for an output-stationary DxD systolic multiply array: buffers A/B,
// clears the PEs, streams skewed operands into the edges, then serializes C.
module systolic_mm_ctrl
  import systolic_pkg::*;
#(
  parameter int DIMENSION = 4,
  parameter int I_BITS    = 8,
  parameter int O_BITS    = 2 * I_BITS + $clog2(DIMENSION)
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic                                  i_start,
  input  logic                                  i_wr_en,
  input  logic                                  i_wr_sel,
  input  logic [$clog2(DIMENSION*DIMENSION)-1:0] i_wr_addr,
  input  logic [I_BITS-1:0]                     i_wr_data,
  output logic                                  o_busy,
  output logic                                  o_array_reset,
  output logic [DIMENSION*I_BITS-1:0]           o_a_edge,
  output logic [DIMENSION*I_BITS-1:0]           o_b_edge,
  input  logic [DIMENSION*DIMENSION*O_BITS-1:0] i_c_flat,
  output logic [O_BITS-1:0]                     o_c_data,
  output logic                                  o_c_valid,
  input  logic                                  i_c_ready,
  output logic                                  o_c_last,
  output logic                                  o_done
);

  localparam int NE          = DIMENSION * DIMENSION;
  localparam int AW          = $clog2(NE);
  localparam int FEED_CYCLES = feed_cycles(DIMENSION);
  localparam int TW          = count_width(FEED_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(FEED_CYCLES - 1);

  state_e                      state_q;
  logic [TW-1:0]               t_q;
  logic [I_BITS-1:0]           a_buf_q [NE];
  logic [I_BITS-1:0]           b_buf_q [NE];
  logic [DIMENSION*I_BITS-1:0] a_edge_q, b_edge_q;
  logic [DIMENSION*I_BITS-1:0] a_edge_d, b_edge_d;
  logic                        busy_q;
  logic                        array_reset_q;
  logic                        capture;
  logic                        ser_fin;
  int                          next_t;

  // Edge lanes for the feed step that the next cycle will present.
  always_comb begin
    next_t   = (state_q == FEED) ? int'(t_q) + 1 : 0;
    a_edge_d = '0;
    b_edge_d = '0;
    for (int l = 0; l < DIMENSION; l++) begin
      if (lane_active(next_t, l, DIMENSION)) begin
        a_edge_d[l*I_BITS +: I_BITS] = a_buf_q[AW'(a_addr(next_t, l, DIMENSION))];
        b_edge_d[l*I_BITS +: I_BITS] = b_buf_q[AW'(b_addr(next_t, l, DIMENSION))];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= IDLE;
      t_q           <= '0;
      a_edge_q      <= '0;
      b_edge_q      <= '0;
      busy_q        <= 1'b0;
      array_reset_q <= 1'b1;
      for (int i = 0; i < NE; i++) begin
        a_buf_q[i] <= '0;
        b_buf_q[i] <= '0;
      end
    end else begin
      array_reset_q <= 1'b0;
      a_edge_q      <= '0;
      b_edge_q      <= '0;
      if (state_q == IDLE && i_wr_en) begin
        if (i_wr_sel) b_buf_q[i_wr_addr] <= i_wr_data;
        else          a_buf_q[i_wr_addr] <= i_wr_data;
      end
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q       <= CLEAR;
            busy_q        <= 1'b1;
            array_reset_q <= 1'b1;
          end
        end
        CLEAR: begin
          state_q  <= FEED;
          t_q      <= '0;
          a_edge_q <= a_edge_d;
          b_edge_q <= b_edge_d;
        end
        FEED: begin
          if (t_q == T_LAST) begin
            state_q <= CAPTURE;
          end else begin
            t_q      <= t_q + 1'b1;
            a_edge_q <= a_edge_d;
            b_edge_q <= b_edge_d;
          end
        end
        CAPTURE: state_q <= OUTPUT;
        OUTPUT: begin
          if (ser_fin) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign capture = (state_q == CAPTURE);

  systolic_result_serializer #(
    .DIMENSION (DIMENSION),
    .O_BITS    (O_BITS)
  ) u_serializer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .capture_i (capture),
    .start_i   (capture),
    .c_flat_i  (i_c_flat),
    .ready_i   (i_c_ready),
    .data_o    (o_c_data),
    .valid_o   (o_c_valid),
    .last_o    (o_c_last),
    .fin_o     (ser_fin),
    .done_o    (o_done)
  );

  assign o_busy        = busy_q;
  assign o_array_reset = array_reset_q;
  assign o_a_edge      = a_edge_q;
  assign o_b_edge      = b_edge_q;

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Directed bench for systolic_mm_ctrl with a behavioural 4x4 output-stationary
// MAC array closing the loop between the operand edges and i_c_flat.
module tb_systolic_mm_ctrl;

  localparam int D  = 4;
  localparam int IB = 8;
  localparam int OB = 18;
  localparam int NE = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, wr_en, wr_sel, c_ready;
  logic [3:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             busy, arst, c_valid, c_last, done;
  logic [D*IB-1:0]  a_edge, b_edge;
  logic [NE*OB-1:0] c_flat;
  logic [OB-1:0]    c_data;

  int tests = 0;
  int fails = 0;

  systolic_mm_ctrl #(.DIMENSION(D), .I_BITS(IB), .O_BITS(OB)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_wr_en(wr_en),
    .i_wr_sel(wr_sel), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_busy(busy), .o_array_reset(arst), .o_a_edge(a_edge), .o_b_edge(b_edge),
    .i_c_flat(c_flat), .o_c_data(c_data), .o_c_valid(c_valid),
    .i_c_ready(c_ready), .o_c_last(c_last), .o_done(done)
  );

  // Behavioural array: a flows east, b flows south, each PE accumulates a*b.
  int acc [D][D];
  int ar  [D][D];
  int br  [D][D];
  int m_a, m_b;
  always @(posedge clk) begin
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) begin
        if (c == 0) m_a = int'($signed(a_edge[r*IB +: IB])); else m_a = ar[r][c-1];
        if (r == 0) m_b = int'($signed(b_edge[c*IB +: IB])); else m_b = br[r-1][c];
        if (arst) begin
          acc[r][c] <= 0; ar[r][c] <= 0; br[r][c] <= 0;
        end else begin
          acc[r][c] <= acc[r][c] + m_a * m_b; ar[r][c] <= m_a; br[r][c] <= m_b;
        end
      end
    end
  end

  always_comb begin
    c_flat = '0;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        c_flat[(r*D+c)*OB +: OB] = OB'(acc[r][c]);
  end

  // Per-job observations
  logic [OB-1:0] got [NE];
  logic [31:0]   a_log [64];
  logic [31:0]   b_log [64];
  int n_got, first_valid_cyc, done_cyc, last_hs_cyc, n_done, n_last, last_flag_idx, stall_viol;
  bit timeout;
  logic [3:0] rpat = 4'b1001;

  task automatic wr(input logic sel, input int addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_identity_seq();
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++) wr(1'b0, r*D+k, (r == k) ? 8'd1 : 8'd0);
    for (int k = 0; k < D; k++)
      for (int c = 0; c < D; c++) wr(1'b1, k*D+c, 8'(4*k+c+1));
  endtask

  // Cycle 0 is the current cycle: start is raised here, observations run from cycle 1.
  task automatic run_job(input int ready_mode, input bit inject);
    logic [OB-1:0] prev_data;
    bit prev_stall;
    n_got = 0; first_valid_cyc = -1; done_cyc = -1; last_hs_cyc = -1; n_done = 0;
    n_last = 0; last_flag_idx = -1; stall_viol = 0; timeout = 1'b1;
    prev_stall = 1'b0; prev_data = '0;
    start = 1'b1; c_ready = 1'b1;
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      if (inject && (cyc == 5 || cyc == 16)) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = (cyc == 16); wr_addr = 4'd0; wr_data = 8'h55;
      end
      c_ready = (ready_mode == 0) ? 1'b1 : rpat[cyc % 4];
      if (cyc < 64) begin a_log[cyc] = a_edge; b_log[cyc] = b_edge; end
      if (prev_stall && c_data !== prev_data) stall_viol++;
      prev_stall = c_valid && !c_ready;
      prev_data  = c_data;
      if (c_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (c_valid && c_ready) begin
        if (n_got < NE) got[n_got] = c_data;
        if (c_last) begin n_last++; last_flag_idx = n_got; end
        n_got++;
        last_hs_cyc = cyc;
      end
      if (done) begin n_done++; if (done_cyc < 0) done_cyc = cyc; end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) begin timeout = 1'b0; break; end
    end
    start = 1'b0; wr_en = 1'b0; c_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; c_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (arst !== 1'b1) begin fails++; $display("FAIL reset_array_reset: got %b expected 1", arst); end
    tests++; if ({c_valid, c_last, done} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {c_valid, c_last, done}); end
    tests++; if ({a_edge, b_edge, c_data} !== '0) begin fails++; $display("FAIL reset_data: got a=%h b=%h c=%h expected 0", a_edge, b_edge, c_data); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (arst !== 1'b0) begin fails++; $display("FAIL reset_release_array_reset: got %b expected 0", arst); end
  endtask

  task automatic test_identity();
    load_identity_seq();
    run_job(0, 1'b0);
    tests++; if (timeout) begin fails++; $display("FAIL ident_timeout: got no done expected done"); end
    tests++; if (first_valid_cyc != 13) begin fails++; $display("FAIL ident_first_valid: got %0d expected 13", first_valid_cyc); end
    tests++; if (done_cyc != 29) begin fails++; $display("FAIL ident_done_cycle: got %0d expected 29", done_cyc); end
    tests++; if (n_got != NE) begin fails++; $display("FAIL ident_count: got %0d expected %0d", n_got, NE); end
    for (int i = 0; i < NE; i++) begin
      tests++; if (got[i] !== OB'(i+1)) begin fails++; $display("FAIL ident_data[%0d]: got %h expected %h", i, got[i], OB'(i+1)); end
    end
    tests++; if (last_flag_idx != 15 || n_last != 1) begin fails++; $display("FAIL ident_last: got idx %0d count %0d expected 15/1", last_flag_idx, n_last); end
    tests++; if (n_done != 1) begin fails++; $display("FAIL ident_done_pulses: got %0d expected 1", n_done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ident_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_negative();
    for (int i = 0; i < NE; i++) wr(1'b0, i, 8'hFF);
    for (int i = 0; i < NE-1; i++) wr(1'b1, i, 8'h02);
    // Final B entry is written in the same cycle as start.
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd15; wr_data = 8'h02;
    run_job(0, 1'b0);
    tests++; if (timeout || n_got != NE) begin fails++; $display("FAIL neg_count: got %0d expected %0d", n_got, NE); end
    for (int i = 0; i < NE; i++) begin
      tests++; if (got[i] !== 18'h3FFF8) begin fails++; $display("FAIL neg_data[%0d]: got %h expected 3fff8", i, got[i]); end
    end
  endtask

  task automatic test_skew();
    logic [31:0] ea, eb;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      ea = '0; eb = '0;
      for (int l = 0; l < D; l++) begin
        if (cyc >= 2 && cyc <= 11 && (cyc - 2) >= l && (cyc - 2) <= l + 3) begin
          ea[l*IB +: IB] = 8'hFF; eb[l*IB +: IB] = 8'h02;
        end
      end
      tests++; if (a_log[cyc] !== ea || b_log[cyc] !== eb) begin
        fails++; $display("FAIL skew_cycle%0d: got a=%h b=%h expected a=%h b=%h", cyc, a_log[cyc], b_log[cyc], ea, eb);
      end
    end
  endtask

  task automatic test_throttle();
    load_identity_seq();
    run_job(1, 1'b0);
    tests++; if (timeout || n_got != NE) begin fails++; $display("FAIL thr_count: got %0d expected %0d", n_got, NE); end
    for (int i = 0; i < NE; i++) begin
      tests++; if (got[i] !== OB'(i+1)) begin fails++; $display("FAIL thr_data[%0d]: got %h expected %h", i, got[i], OB'(i+1)); end
    end
    tests++; if (stall_viol != 0) begin fails++; $display("FAIL thr_stable: got %0d changes expected 0", stall_viol); end
    tests++; if (done_cyc != last_hs_cyc + 1) begin fails++; $display("FAIL thr_done_timing: got %0d expected %0d", done_cyc, last_hs_cyc + 1); end
    tests++; if (n_done != 1 || last_flag_idx != 15) begin fails++; $display("FAIL thr_done_last: got done %0d last %0d expected 1/15", n_done, last_flag_idx); end
  endtask

  task automatic test_ignore_busy();
    for (int pass = 0; pass < 2; pass++) begin
      run_job(0, pass == 0);
      tests++; if (done_cyc != 29 || n_got != NE) begin fails++; $display("FAIL ign%0d_timing: got done %0d count %0d expected 29/16", pass, done_cyc, n_got); end
      for (int i = 0; i < NE; i++) begin
        tests++; if (got[i] !== OB'(i+1)) begin fails++; $display("FAIL ign%0d_data[%0d]: got %h expected %h", pass, i, got[i], OB'(i+1)); end
      end
      tests++; if (n_done != 1) begin fails++; $display("FAIL ign%0d_done_pulses: got %0d expected 1", pass, n_done); end
    end
  endtask

  task automatic test_abort();
    int early_done;
    early_done = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) early_done++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || c_valid !== 1'b0) begin fails++; $display("FAIL abort_idle: got busy %b valid %b expected 0/0", busy, c_valid); end
    tests++; if (arst !== 1'b1) begin fails++; $display("FAIL abort_array_reset: got %b expected 1", arst); end
    tests++; if ({a_edge, b_edge} !== '0) begin fails++; $display("FAIL abort_edges: got %h expected 0", {a_edge, b_edge}); end
    rst = 1'b0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(posedge clk); #1;
      if (done) early_done++;
      if (cyc == 0) begin
        tests++; if (arst !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abort_release: got arst %b busy %b expected 0/0", arst, busy); end
      end
    end
    tests++; if (early_done != 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses expected 0", early_done); end
    run_job(0, 1'b0);
    tests++; if (timeout || n_got != NE || done_cyc != 29) begin fails++; $display("FAIL abort_rerun: got count %0d done %0d expected 16/29", n_got, done_cyc); end
    for (int i = 0; i < NE; i++) begin
      tests++; if (got[i] !== '0) begin fails++; $display("FAIL abort_cleared[%0d]: got %h expected 0", i, got[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_negative();
    test_skew();
    test_throttle();
    test_ignore_busy();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
